inst_buffer: RTL and testbench



---
 rtl/inst_buffer_pkg.sv | 18 +
 rtl/inst_buffer.sv | 87 ++++++++
 tb/tb_inst_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared fetch/decode constants and the instruction buffer entry type.
package inst_buffer_pkg;

  localparam int InstAddrBus      = 32;
  localparam int InstBus          = 32;
  localparam logic Flush          = 1'b1;
  localparam logic RstEnable      = 1'b0;

  // Sizing shared with the PC stage so its throttle matches the buffer.
  localparam int IBUF_DEPTH       = 16;
  localparam int IBUF_FULL_MARGIN = 4;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Dual-in / dual-out instruction buffer between fetch and decode.
// Circular array with head/tail pointers; flush empties it in one cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH       = IBUF_DEPTH,
  parameter int PTR_W       = 4,
  parameter int FULL_MARGIN = IBUF_FULL_MARGIN
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push_valid_1,
  input  logic [InstAddrBus-1:0] push_pc_1,
  input  logic [InstBus-1:0]     push_inst_1,
  input  logic                   push_valid_2,
  input  logic [InstAddrBus-1:0] push_pc_2,
  input  logic [InstBus-1:0]     push_inst_2,
  input  logic [1:0]             pop_num,
  output logic                   out_valid_1,
  output logic [InstAddrBus-1:0] out_pc_1,
  output logic [InstBus-1:0]     out_inst_1,
  output logic                   out_valid_2,
  output logic [InstAddrBus-1:0] out_pc_2,
  output logic [InstBus-1:0]     out_inst_2,
  output logic                   ibuffer_full,
  output logic [PTR_W:0]         count
);

  localparam logic [PTR_W:0] DEPTH_W  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] MARGIN_W = (PTR_W+1)'(FULL_MARGIN);

  ibuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [PTR_W:0]   count_q, free, push_ext, pop_ext, push_acc_n, pop_eff;
  logic [1:0]       push_n;
  logic             push_ok;

  always_comb begin
    push_n     = push_valid_1 ? (push_valid_2 ? 2'd2 : 2'd1) : 2'd0;
    push_ext   = {{(PTR_W-1){1'b0}}, push_n};
    pop_ext    = {{(PTR_W-1){1'b0}}, pop_num};
    free       = DEPTH_W - count_q;
    // Capacity is judged before this cycle's pops; an oversize push is dropped whole.
    push_ok    = (push_ext <= free);
    push_acc_n = push_ok ? push_ext : '0;
    pop_eff    = (pop_ext > count_q) ? count_q : pop_ext;
    head_p1    = head + PTR_W'(1);
    tail_p1    = tail + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (resetn == RstEnable) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush == Flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + pop_eff[PTR_W-1:0];
      tail    <= tail + push_acc_n[PTR_W-1:0];
      count_q <= count_q + push_acc_n - pop_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn != RstEnable && flush != Flush && push_acc_n != '0) begin
      mem[tail] <= '{pc: push_pc_1, inst: push_inst_1};
      if (push_n == 2'd2)
        mem[tail_p1] <= '{pc: push_pc_2, inst: push_inst_2};
    end
  end

  always_comb begin
    out_valid_1  = (count_q >= (PTR_W+1)'(1));
    out_valid_2  = (count_q >= (PTR_W+1)'(2));
    out_pc_1     = out_valid_1 ? mem[head].pc      : '0;
    out_inst_1   = out_valid_1 ? mem[head].inst    : '0;
    out_pc_2     = out_valid_2 ? mem[head_p1].pc   : '0;
    out_inst_2   = out_valid_2 ? mem[head_p1].inst : '0;
    ibuffer_full = (free < MARGIN_W);
    count        = count_q;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: driver pushes expected post-edge state,
// monitor compares on the falling edge.
module tb_inst_buffer;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        push_valid_1, push_valid_2;
  logic [31:0] push_pc_1, push_inst_1, push_pc_2, push_inst_2;
  logic [1:0]  pop_num;
  logic        out_valid_1, out_valid_2, ibuffer_full;
  logic [31:0] out_pc_1, out_inst_1, out_pc_2, out_inst_2;
  logic [4:0]  count;

  inst_buffer dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push_valid_1(push_valid_1), .push_pc_1(push_pc_1), .push_inst_1(push_inst_1),
    .push_valid_2(push_valid_2), .push_pc_2(push_pc_2), .push_inst_2(push_inst_2),
    .pop_num(pop_num),
    .out_valid_1(out_valid_1), .out_pc_1(out_pc_1), .out_inst_1(out_inst_1),
    .out_valid_2(out_valid_2), .out_pc_2(out_pc_2), .out_inst_2(out_inst_2),
    .ibuffer_full(ibuffer_full), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          hc;
    logic        v1, v2, full;
    logic [31:0] pc1, i1, pc2, i2;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_gen   = 32'hBFC0_0000;
  logic [31:0] inst_gen = 32'h2401_0001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count",  32'(count), 32'(e.hc));
      chk("valid1", 32'(out_valid_1), 32'(e.v1));
      chk("valid2", 32'(out_valid_2), 32'(e.v2));
      chk("pc1",    out_pc_1, e.pc1);
      chk("inst1",  out_inst_1, e.i1);
      chk("pc2",    out_pc_2, e.pc2);
      chk("inst2",  out_inst_2, e.i2);
      chk("full",   32'(ibuffer_full), 32'(e.full));
    end
  end

  // hc is the hand-computed occupancy after this cycle's edge.
  task automatic step(input logic rst, input logic fl, input logic v1, input logic v2,
                      input logic [1:0] pop, input int hc);
    exp_t e;
    int   pn, pe, sz;
    resetn       = rst;
    flush        = fl;
    push_valid_1 = v1;
    push_valid_2 = v2;
    push_pc_1    = pc_gen;
    push_inst_1  = inst_gen;
    push_pc_2    = pc_gen + 32'd4;
    push_inst_2  = inst_gen + 32'h0001_0001;
    pop_num      = pop;
    @(posedge clk);
    if (!rst || fl) begin
      model.delete();
    end else begin
      pn = v1 ? (v2 ? 2 : 1) : 0;
      sz = model.size();
      pe = (int'(pop) < sz) ? int'(pop) : sz;
      for (int k = 0; k < pe; k++) void'(model.pop_front());
      if (pn <= 16 - sz) begin
        if (pn >= 1) model.push_back({push_pc_1, push_inst_1});
        if (pn == 2) model.push_back({push_pc_2, push_inst_2});
      end
    end
    if (v1) begin
      pc_gen   = pc_gen + 32'd8;
      inst_gen = inst_gen + 32'h0002_0002;
    end
    sz     = model.size();
    e.hc   = hc;
    e.v1   = sz >= 1;
    e.v2   = sz >= 2;
    e.pc1  = e.v1 ? model[0][63:32] : 32'h0;
    e.i1   = e.v1 ? model[0][31:0]  : 32'h0;
    e.pc2  = e.v2 ? model[1][63:32] : 32'h0;
    e.i2   = e.v2 ? model[1][31:0]  : 32'h0;
    e.full = (16 - sz) < 4;
    if (sz != hc) begin
      errors++;
      $display("FAIL model_count actual=%0d required=%0d", sz, hc);
    end
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; push_valid_1 = 1'b0; push_valid_2 = 1'b0;
    push_pc_1 = '0; push_inst_1 = '0; push_pc_2 = '0; push_inst_2 = '0; pop_num = 2'd0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // First pair: BFC00000/24010001 and BFC00004/24020002.
    step(1, 0, 1, 1, 0, 2);
    step(1, 0, 0, 0, 0, 2);
    step(1, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 2, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 0, 2 * (i + 1));
    step(1, 0, 1, 0, 0, 13);
    step(1, 0, 1, 1, 0, 15);
    step(1, 0, 1, 1, 0, 15);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 2, 13 - 2 * i);
    step(1, 0, 0, 0, 1, 0);
    // Same-cycle push and over-pop at count 1.
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 2, 2);
    step(1, 0, 0, 0, 2, 0);
    // Park head at 14, then push across the wrap.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 1, 2, 2);
    step(1, 0, 0, 0, 2, 0);
    step(1, 0, 1, 1, 0, 2);
    step(1, 0, 1, 1, 0, 4);
    step(1, 0, 0, 0, 2, 2);
    step(1, 0, 0, 0, 2, 0);
    // Flush at count 10 with push and pop in the same cycle.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0, 2 * (i + 1));
    step(1, 1, 1, 0, 2, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 2);
    step(0, 1, 1, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
